// File: rtl/j1_pkg.sv
// rtl/j1_pkg.sv - instruction classes, ALU op/func encodings and delta helper for j1_core_p
package j1_pkg;

  typedef enum logic [2:0] {
    CLS_JMP  = 3'd0,
    CLS_CJMP = 3'd1,
    CLS_CALL = 3'd2,
    CLS_ALU  = 3'd3,
    CLS_LIT  = 3'd4
  } insn_cls_e;

  typedef enum logic [3:0] {
    OP_T     = 4'd0,
    OP_N     = 4'd1,
    OP_ADD   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_INV   = 4'd6,
    OP_EQ    = 4'd7,
    OP_LT    = 4'd8,
    OP_SRA   = 4'd9,
    OP_SHL   = 4'd10,
    OP_R     = 4'd11,
    OP_SUB   = 4'd12,
    OP_IO    = 4'd13,
    OP_DEPTH = 4'd14,
    OP_ULT   = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    FN_NONE  = 3'd0,
    FN_T2N   = 3'd1,
    FN_T2R   = 3'd2,
    FN_MEMWR = 3'd3,
    FN_IOWR  = 3'd4,
    FN_IORD  = 3'd5,
    FN_IEWR  = 3'd6,
    FN_RSVD  = 3'd7
  } alu_func_e;

  // Literal bit dominates; otherwise insn[14:13] selects the class.
  function automatic insn_cls_e insn_class(input logic [2:0] top);
    if (top[2]) return CLS_LIT;
    return insn_cls_e'({1'b0, top[1:0]});
  endfunction

  function automatic logic [7:0] delta_sext(input logic [1:0] d);
    return {{6{d[1]}}, d};
  endfunction

endpackage

// File: rtl/j1_stack.sv
// rtl/j1_stack.sv - register-file stack with pointer, signed delta move and over/underflow pulse
module j1_stack
  import j1_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     move_i,
  input  logic                     we_i,
  input  logic [1:0]               delta_i,
  input  logic [WIDTH-1:0]         wd_i,
  output logic [WIDTH-1:0]         top_o,
  output logic [$clog2(DEPTH)-1:0] sp_o,
  output logic                     err_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    sp_q, sp_d;

  always_comb begin
    sp_d = sp_q;
    if (move_i) sp_d = sp_q + AW'(delta_sext(delta_i));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sp_q <= '0;
    else         sp_q <= sp_d;
  end

  // The new top lands at the updated pointer, so a push writes the slot it moves onto.
  always_ff @(posedge clk_i) begin
    if (move_i && we_i) mem_q[sp_d] <= wd_i;
  end

  assign top_o = mem_q[sp_q];
  assign sp_o  = sp_q;

  always_comb begin
    err_o = 1'b0;
    if (move_i) begin
      case (delta_i)
        2'b01:   err_o = (sp_q == AW'(DEPTH - 1));
        2'b11:   err_o = (sp_q == '0);
        2'b10:   err_o = (sp_q <= AW'(1));
        default: err_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/j1_core_p.sv
// rtl/j1_core_p.sv - parametrised J1 stack CPU with I/O stall and stack error flag
// Optional single-level interrupt with the irq port is built when J1_IRQ_EN is defined.
module j1_core_p
  import j1_pkg::*;
#(
  parameter int                 WIDTH      = 16,
  parameter int                 CODE_AW    = 13,
  parameter int                 DSTK_DEPTH = 16,
  parameter int                 RSTK_DEPTH = 16,
  parameter logic [CODE_AW-1:0] IRQ_VECTOR = 13'h0002
) (
  input  logic               clk,
  input  logic               resetq,
  output logic [CODE_AW-1:0] code_addr,
  input  logic [15:0]        insn,
  output logic [WIDTH-1:0]   mem_addr,
  output logic               mem_wr,
  output logic [WIDTH-1:0]   dout,
  output logic               io_rd,
  output logic               io_wr,
  input  logic [WIDTH-1:0]   io_din,
  input  logic               io_ready,
`ifdef J1_IRQ_EN
  input  logic               irq,
`endif
  output logic               dstk_err
);

  localparam int DAW = $clog2(DSTK_DEPTH);
  localparam int RAW = $clog2(RSTK_DEPTH);

  logic [CODE_AW-1:0] pc_q, pc_d, pc_plus_1, target;
  logic [WIDTH-1:0]   st0_q, st0_d, st1, rst0, alu, rwd;
  logic               reboot_q, dstk_err_q;
  logic [DAW-1:0]     dsp;
  logic [RAW-1:0]     unused_rsp;
  logic               unused_rstk_err;
  logic               stall, take_irq, io_access;
  logic               dmove, dwe, rmove, rwe, dstk_err_pulse;
  logic [1:0]         ddelta, rdelta;
  insn_cls_e          cls;
  alu_op_e            op;
  alu_func_e          func;

  assign cls       = insn_class(insn[15:13]);
  assign op        = alu_op_e'(insn[11:8]);
  assign func      = alu_func_e'(insn[6:4]);
  assign pc_plus_1 = pc_q + CODE_AW'(1);
  assign target    = CODE_AW'(insn[12:0]);

  assign io_access = (cls == CLS_ALU) && ((func == FN_IORD) || (func == FN_IOWR));
  assign stall     = !reboot_q && io_access && !io_ready;

`ifdef J1_IRQ_EN
  logic ie_q, ie_d;
  assign take_irq = irq && ie_q && !reboot_q && !stall;
`else
  localparam logic [CODE_AW-1:0] unused_irq_vector = IRQ_VECTOR;
  assign take_irq = 1'b0;
`endif

  always_comb begin
    alu = st0_q;
    case (op)
      OP_T:     alu = st0_q;
      OP_N:     alu = st1;
      OP_ADD:   alu = st0_q + st1;
      OP_AND:   alu = st0_q & st1;
      OP_OR:    alu = st0_q | st1;
      OP_XOR:   alu = st0_q ^ st1;
      OP_INV:   alu = ~st0_q;
      OP_EQ:    alu = {WIDTH{st1 == st0_q}};
      OP_LT:    alu = {WIDTH{$signed(st1) < $signed(st0_q)}};
      OP_SRA:   alu = WIDTH'($signed(st0_q) >>> 1);
      OP_SHL:   alu = st0_q << 1;
      OP_R:     alu = rst0;
      OP_SUB:   alu = st1 - st0_q;
      OP_IO:    alu = io_din;
      OP_DEPTH: alu = WIDTH'(dsp);
      OP_ULT:   alu = {WIDTH{st1 < st0_q}};
      default:  alu = st0_q;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    st0_d  = st0_q;
    dmove  = 1'b0;
    dwe    = 1'b0;
    ddelta = 2'b00;
    rmove  = 1'b0;
    rwe    = 1'b0;
    rdelta = 2'b00;
    rwd    = WIDTH'({pc_plus_1, 1'b0});
    mem_wr = 1'b0;
    io_rd  = 1'b0;
    io_wr  = 1'b0;
`ifdef J1_IRQ_EN
    ie_d   = ie_q;
`endif
    if (reboot_q) begin
      pc_d = '0;
    end else if (stall) begin
      io_rd = (func == FN_IORD);
      io_wr = (func == FN_IOWR);
    end else if (take_irq) begin
      // Push the preempted pc itself so that instruction runs again after return.
      pc_d   = IRQ_VECTOR;
      rmove  = 1'b1;
      rwe    = 1'b1;
      rdelta = 2'b01;
      rwd    = WIDTH'({pc_q, 1'b0});
`ifdef J1_IRQ_EN
      ie_d   = 1'b0;
`endif
    end else begin
      dmove = 1'b1;
      rmove = 1'b1;
      case (cls)
        CLS_LIT: begin
          pc_d   = pc_plus_1;
          st0_d  = WIDTH'(insn[14:0]);
          dwe    = 1'b1;
          ddelta = 2'b01;
        end
        CLS_JMP: pc_d = target;
        CLS_CJMP: begin
          pc_d   = (st0_q == '0) ? target : pc_plus_1;
          st0_d  = st1;
          ddelta = 2'b11;
        end
        CLS_CALL: begin
          pc_d   = target;
          rwe    = 1'b1;
          rdelta = 2'b01;
        end
        CLS_ALU: begin
          pc_d   = insn[7] ? rst0[CODE_AW:1] : pc_plus_1;
          st0_d  = alu;
          ddelta = insn[1:0];
          rdelta = insn[3:2];
          dwe    = (func == FN_T2N);
          rwe    = (func == FN_T2R);
          if (func == FN_T2R) rwd = st0_q;
          mem_wr = (func == FN_MEMWR);
          io_wr  = (func == FN_IOWR);
          io_rd  = (func == FN_IORD);
`ifdef J1_IRQ_EN
          if (func == FN_IEWR) ie_d = st0_q[0];
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      pc_q       <= '0;
      st0_q      <= '0;
      reboot_q   <= 1'b1;
      dstk_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      st0_q      <= st0_d;
      reboot_q   <= 1'b0;
      dstk_err_q <= dstk_err_q | dstk_err_pulse;
    end
  end

`ifdef J1_IRQ_EN
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) ie_q <= 1'b0;
    else         ie_q <= ie_d;
  end
`endif

  j1_stack #(.WIDTH(WIDTH), .DEPTH(DSTK_DEPTH)) u_dstk (
    .clk_i   (clk),
    .rst_ni  (resetq),
    .move_i  (dmove),
    .we_i    (dwe),
    .delta_i (ddelta),
    .wd_i    (st0_q),
    .top_o   (st1),
    .sp_o    (dsp),
    .err_o   (dstk_err_pulse)
  );

  j1_stack #(.WIDTH(WIDTH), .DEPTH(RSTK_DEPTH)) u_rstk (
    .clk_i   (clk),
    .rst_ni  (resetq),
    .move_i  (rmove),
    .we_i    (rwe),
    .delta_i (rdelta),
    .wd_i    (rwd),
    .top_o   (rst0),
    .sp_o    (unused_rsp),
    .err_o   (unused_rstk_err)
  );

  assign code_addr = pc_d;
  assign mem_addr  = st0_q;
  assign dout      = st1;
  assign dstk_err  = dstk_err_q;

endmodule

// File: tb/tb_j1_core_p.sv
// tb/tb_j1_core_p.sv - directed self-checking bench for j1_core_p (16- and 32-bit instances)
module tb_j1_core_p;

  logic clk = 1'b0;
  logic resetq = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] code_addr16, code_addr32;
  logic [15:0] insn16 = 16'h6000, insn32 = 16'h6000;
  logic [15:0] mem_addr16, dout16, io_din16 = '0;
  logic [31:0] mem_addr32, dout32;
  logic [31:0] io_din32 = '0;
  logic        mem_wr16, io_rd16, io_wr16, dstk_err16, io_ready16 = 1'b1;
  logic        mem_wr32, io_rd32, io_wr32, dstk_err32;
  logic        io_ready32 = 1'b1;
`ifdef J1_IRQ_EN
  logic        irq16 = 1'b0;
  logic        irq32 = 1'b0;
`endif

  logic [15:0] rom16 [8192];
  logic [15:0] rom32 [8192];
  always @(posedge clk) insn16 <= rom16[code_addr16];
  always @(posedge clk) insn32 <= rom32[code_addr32];

  j1_core_p u_d16 (
    .clk(clk), .resetq(resetq), .code_addr(code_addr16), .insn(insn16),
    .mem_addr(mem_addr16), .mem_wr(mem_wr16), .dout(dout16),
    .io_rd(io_rd16), .io_wr(io_wr16), .io_din(io_din16), .io_ready(io_ready16),
`ifdef J1_IRQ_EN
    .irq(irq16),
`endif
    .dstk_err(dstk_err16)
  );

  j1_core_p #(.WIDTH(32)) u_d32 (
    .clk(clk), .resetq(resetq), .code_addr(code_addr32), .insn(insn32),
    .mem_addr(mem_addr32), .mem_wr(mem_wr32), .dout(dout32),
    .io_rd(io_rd32), .io_wr(io_wr32), .io_din(io_din32), .io_ready(io_ready32),
`ifdef J1_IRQ_EN
    .irq(irq32),
`endif
    .dstk_err(dstk_err32)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear16();
    for (int i = 0; i < 8192; i++) rom16[i] = 16'h6000;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    resetq = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    resetq = 1'b1;
    #1;
  endtask

  task automatic next();
    @(negedge clk);
    #1;
  endtask

  logic [3:0]  f_op  [12];
  logic [31:0] f_exp [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values, reboot cycle and 32-bit arithmetic run side by side.
    resetq = 1'b0;
    clear16();
    for (int i = 0; i < 8192; i++) rom32[i] = 16'h6000;
    rom16[0] = 16'h6030;
    rom32[0] = 16'h8000; rom32[1] = 16'h8001; rom32[2] = 16'h6C03;
    rom32[3] = 16'h8000; rom32[4] = 16'h6803;
    repeat (3) @(negedge clk);
    #1;
    check("rst_code_addr", 32'(code_addr16), 32'd0);
    check("rst_strobes", {29'd0, mem_wr16, io_rd16, io_wr16}, 32'd0);
    check("rst_T", 32'(mem_addr16), 32'd0);
    check("rst_dstk_err", 32'(dstk_err16), 32'd0);
    resetq = 1'b1;
    #1;
    check("reboot_code_addr", 32'(code_addr16), 32'd0);
    check("reboot_mem_wr", 32'(mem_wr16), 32'd0);
    next();
    check("exec0_code_addr", 32'(code_addr16), 32'd1);
    check("exec0_mem_wr", 32'(mem_wr16), 32'd1);
    next();
    check("exec1_code_addr", 32'(code_addr16), 32'd2);
    check("exec1_mem_wr", 32'(mem_wr16), 32'd0);
    next();
    check("exec2_code_addr", 32'(code_addr16), 32'd3);
    next();
    check("w32_sub", mem_addr32, 32'hFFFF_FFFF);
    next();
    check("w32_lit0", mem_addr32, 32'd0);
    next();
    check("w32_slt", mem_addr32, 32'hFFFF_FFFF);
    check("w32_N", dout32, 32'd0);

    // Literals, add and depth.
    hold_reset();
    clear16();
    rom16[0] = 16'h8005; rom16[1] = 16'h8003; rom16[2] = 16'h6203; rom16[3] = 16'h6E11;
    release_reset();
    next();
    next();
    check("lit5_T", 32'(mem_addr16), 32'd5);
    next();
    check("lit3_T", 32'(mem_addr16), 32'd3);
    check("lit3_N", 32'(dout16), 32'd5);
    next();
    check("add_T", 32'(mem_addr16), 32'd8);
    next();
    check("depth_T", 32'(mem_addr16), 32'd1);
    check("depth_N", 32'(dout16), 32'd8);

    // ALU ops with N=6, T=3, each result popped into T.
    f_op  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd15};
    f_exp = '{32'd6, 32'd9, 32'd2, 32'd7, 32'd5, 32'hFFFC, 32'd0, 32'd0,
              32'd1, 32'd6, 32'd3, 32'd0};
    hold_reset();
    clear16();
    for (int i = 0; i < 12; i++) begin
      rom16[3*i]   = 16'h8006;
      rom16[3*i+1] = 16'h8003;
      rom16[3*i+2] = 16'h6003 | {4'h0, f_op[i], 8'h00};
    end
    release_reset();
    next();
    for (int i = 0; i < 12; i++) begin
      repeat (3) next();
      check($sformatf("alu_op%0d", f_op[i]), 32'(mem_addr16), f_exp[i]);
    end

    // Jump, call, return and both conditional-jump outcomes.
    hold_reset();
    clear16();
    rom16[0] = 16'h0005; rom16[5] = 16'h4014; rom16[20] = 16'h608C;
    rom16[6] = 16'h8000; rom16[7] = 16'h2009; rom16[9] = 16'h8001; rom16[10] = 16'h200F;
    release_reset();
    next();
    check("jmp", 32'(code_addr16), 32'd5);
    next();
    check("call", 32'(code_addr16), 32'd20);
    next();
    check("ret", 32'(code_addr16), 32'd6);
    next();
    next();
    check("cjmp_taken", 32'(code_addr16), 32'd9);
    next();
    next();
    check("cjmp_not_taken", 32'(code_addr16), 32'd11);

    // I/O read with three wait states, then zero-wait io_wr.
    hold_reset();
    clear16();
    rom16[0] = 16'h6D50; rom16[1] = 16'h6040;
    io_ready16 = 1'b0;
    io_din16 = 16'h0000;
    release_reset();
    for (int k = 1; k <= 3; k++) begin
      next();
      check($sformatf("stall%0d_io_rd", k), 32'(io_rd16), 32'd1);
      check($sformatf("stall%0d_code_addr", k), 32'(code_addr16), 32'd0);
    end
    @(negedge clk);
    io_ready16 = 1'b1;
    io_din16 = 16'h1234;
    #1;
    check("ready_io_rd", 32'(io_rd16), 32'd1);
    check("ready_code_addr", 32'(code_addr16), 32'd1);
    next();
    check("io_rd_T", 32'(mem_addr16), 32'h1234);
    check("io_rd_done", 32'(io_rd16), 32'd0);
    check("io_wr_zero_wait", 32'(io_wr16), 32'd1);
    check("io_wr_code_addr", 32'(code_addr16), 32'd2);

    // Reset asserted in the middle of a stall.
    hold_reset();
    clear16();
    rom16[0] = 16'h6D50;
    io_ready16 = 1'b0;
    release_reset();
    next();
    check("midstall_io_rd", 32'(io_rd16), 32'd1);
    resetq = 1'b0;
    #1;
    check("midstall_rst_io_rd", 32'(io_rd16), 32'd0);
    check("midstall_rst_code_addr", 32'(code_addr16), 32'd0);
    io_ready16 = 1'b1;

    // Seventeen pushes into a 16-deep data stack.
    clear16();
    for (int i = 0; i < 17; i++) rom16[i] = 16'h8001;
    release_reset();
    for (int k = 1; k <= 20; k++) begin
      next();
      if (k == 16) check("ovf_after15", 32'(dstk_err16), 32'd0);
      if (k == 17) check("ovf_after16", 32'(dstk_err16), 32'd1);
      if (k == 20) check("ovf_sticky", 32'(dstk_err16), 32'd1);
    end
    hold_reset();
    #1;
    check("ovf_reset_clears", 32'(dstk_err16), 32'd0);

    // Pop from an empty data stack.
    clear16();
    rom16[0] = 16'h6103;
    release_reset();
    next();
    check("udf_before", 32'(dstk_err16), 32'd0);
    next();
    check("udf_after", 32'(dstk_err16), 32'd1);

`ifdef J1_IRQ_EN
    // Interrupt at pc=5: vector, read R, return, then ie stays clear.
    hold_reset();
    clear16();
    rom16[0] = 16'h0003; rom16[2] = 16'h0008; rom16[3] = 16'h8001; rom16[4] = 16'h6163;
    rom16[8] = 16'h6B11; rom16[9] = 16'h608C;
    release_reset();
    next();
    next();
    next();
    check("irq_pre_code_addr", 32'(code_addr16), 32'd5);
    @(negedge clk);
    irq16 = 1'b1;
    #1;
    check("irq_vector", 32'(code_addr16), 32'd2);
    @(negedge clk);
    irq16 = 1'b0;
    #1;
    check("irq_vec_jmp", 32'(code_addr16), 32'd8);
    next();
    next();
    check("irq_R", 32'(mem_addr16), 32'd10);
    check("irq_return", 32'(code_addr16), 32'd5);
    next();
    @(negedge clk);
    irq16 = 1'b1;
    #1;
    check("irq_ie_cleared", 32'(code_addr16), 32'd7);
    irq16 = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/j1_core_p.md
# j1_core_p

Parametrised successor to the 16-bit J1 stack CPU core: same instruction encoding, generalised data width, stack depths and code address width. Adds an I/O ready/stall handshake, stack-depth reporting and an optional single-level interrupt. Sits between the synchronous code RAM, the data RAM and the I/O bus in the microForth FPGA top level.

## Interface
- WIDTH, 16: data width; 16 or 32.
- CODE_AW, 13: code address width in words; at most WIDTH-2.
- DSTK_DEPTH, 16: data stack entries; power of 2, 4..256.
- RSTK_DEPTH, 16: return stack entries; power of 2, 4..256.
- IRQ_VECTOR, 13'h0002: interrupt entry address; CODE_AW bits.
- clk  in  1  clock; all logic on the rising edge.
- resetq  in  1  reset; asynchronous, active-low.
- code_addr  out  CODE_AW  next instruction address, to the synchronous code RAM.
- insn  in  16  instruction word read at code_addr in the previous cycle.
- mem_addr  out  WIDTH  data address; equals T.
- mem_wr  out  1  data write strobe.
- dout  out  WIDTH  write data; equals N.
- io_rd  out  1  I/O read strobe.
- io_wr  out  1  I/O write strobe.
- io_din  in  WIDTH  I/O read data.
- io_ready  in  1  I/O access complete.
- irq  in  1  level interrupt request; present only with J1_IRQ_EN.
- dstk_err  out  1  sticky flag: data stack overflow or underflow.

## Operation
- Decode on insn[15:13]:
  - insn[15]=1: literal; push insn[14:0] zero-extended.
  - 000: jump.
  - 001: conditional jump; taken when T==0; always pops.
  - 010: call; pushes {pc+1,1'b0} onto R.
  - 011: ALU.
- ALU fields:
  - insn[11:8]: op, in order T, N, T+N, T&N, T|N, T^N, ~T, =, signed <, arithmetic >>1, <<1, R, N-T, io_din, depth, unsigned <.
  - insn[7]: R->PC.
  - insn[6:4]: func; 1 T->N, 2 T->R, 3 mem_wr, 4 io_wr, 5 io_rd, 6 interrupt-enable write.
  - insn[3:2]: R delta, 2-bit signed.
  - insn[1:0]: D delta, 2-bit signed.
- The depth op returns the data stack pointer zero-extended to WIDTH.
- Comparison results are all ones or all zeros. Arithmetic is modulo 2^WIDTH.
- Return: pc <= R[CODE_AW:1].
- Stacks are register files. Pointers wrap modulo depth.
- dstk_err sets when:
  - a push occurs at dsp==DSTK_DEPTH-1; or
  - a pop occurs at dsp==0.
  dstk_err clears only on reset.
- I/O stall: when io_rd or io_wr is asserted and io_ready is low, the core freezes:
  - pc, dsp, rsp, T and both stack RAMs hold;
  - code_addr = pc, so the same insn re-presents;
  - the strobe stays high.
  The instruction completes in the cycle io_ready is high.
- mem_wr never stalls.

## Timing
- Reset values: pc=0, dsp=0, rsp=0, T=0, dstk_err=0, ie=0, reboot=1.
- Reset outputs: code_addr=0, and all strobes 0.
- First cycle after reset release (reboot):
  - no instruction executes;
  - strobes are suppressed;
  - pcN=0.
  Execution starts at address 0 on the next cycle.
- Throughput: one instruction per cycle when no stall. Branches have no penalty, because code_addr is combinational pcN.
- io_rd data is sampled from io_din in the completing cycle.
- io_ready high on the first strobe cycle gives zero wait states.
- Reset mid-stall: the strobe drops asynchronously and the core restarts at 0.

## Configuration
- J1_IRQ_EN defined:
  - the irq port exists, along with internal flag ie (reset 0; written by func 6 from T[0]).
  - When irq && ie and no stall, the current insn is replaced by a call to IRQ_VECTOR.
  - The return address pushed is {pc,1'b0}, so the preempted instruction re-executes after return.
  - ie clears on entry.
  - A pending irq never interrupts a stalled instruction.
- J1_IRQ_EN undefined:
  - there is no irq port and no ie;
  - func 6 is a no-op.

## Structure
- Package j1_pkg holds:
  - opcode-class constants (LIT, JMP, CJMP, CALL, ALU);
  - ALU op and func enums;
  - a function for the 2-bit signed delta.
- One sub-module, j1_stack: parametrised WIDTH/DEPTH register-file stack with write enable, delta, top output and an error pulse. It is instantiated twice, for the data and return stacks.

## Test plan
- Reset release: code_addr 0 for two cycles, then the core fetches 0, 1, 2. All strobes stay 0 during reboot.
- Literal 16'h8005, literal 16'h8003, ALU T+N: T=8 and depth=1.
- WIDTH=32: program computing 0 - 1 → T=32'hFFFF_FFFF. Signed < of (-1, 0) gives all ones.
- io_rd with io_ready low for 3 cycles, then io_din=16'h1234:
  - io_rd high for 4 cycles;
  - code_addr constant throughout;
  - T=16'h1234 afterwards.
- 17 pushes with DSTK_DEPTH=16: dstk_err rises on push 16 and stays high until reset.
- J1_IRQ_EN: ie=1, irq pulse at pc=5 → next pc=IRQ_VECTOR and R holds 10. A return resumes at 5, and ie reads 0 until rewritten.
